sumador_completo: RTL and testbench

- WIDTH-bit full adder (a + b + cin) built from a ripple chain of 1-bit full-adder cells, with registered outputs.
- Default WIDTH=1 reproduces the classic single-bit full adder truth table, one clock after the inputs are sampled.
- Used as a leaf arithmetic block wherever a carry-in/carry-out adder with a valid qualifier is needed.

---
 rtl/sumador_pkg.sv | 19 +
 rtl/sumador_completo_fa_cell.sv | 23 ++
 rtl/sumador_completo.sv | 67 ++++++
 tb/tb_sumador_completo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// Shared types, limits and the 1-bit reference model for the ripple adder.
// The optional signed-overflow output is controlled by SUMADOR_OVF_EN.
package sumador_pkg;

   localparam int SUMADOR_MAX_WIDTH = 64;

   typedef struct packed {
      logic s;
      logic c;
   } fa_out_t;

   function automatic fa_out_t fa_ref(input logic a, input logic b, input logic c);
      fa_out_t r;
      r.s = a ^ b ^ c;
      r.c = (a & b) | (c & (a ^ b));
      return r;
   endfunction

endpackage

// File: rtl/sumador_completo_fa_cell.sv
// 1-bit combinational full-adder cell, one link of the ripple carry chain.
// Built the same way whether or not SUMADOR_OVF_EN is defined.
module fa_cell
   import sumador_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   fa_out_t r;
   logic    p;

   assign p   = a ^ b;
   assign r.s = p ^ ci;
   assign r.c = (a & b) | (ci & p);

   assign s  = r.s;
   assign co = r.c;

endmodule

// File: rtl/sumador_completo.sv
// WIDTH-bit ripple-carry full adder with registered sum/cout/out_valid.
// Defining SUMADOR_OVF_EN adds a registered two's-complement overflow output ovf.
module sumador_completo
   import sumador_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SUMADOR_OVF_EN
   output logic             ovf,
`endif
   output logic             out_valid
);

   if (WIDTH < 1 || WIDTH > SUMADOR_MAX_WIDTH) begin : g_bad_width
      $error("sumador_completo: WIDTH out of range");
   end

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   // Results only move on a valid edge; otherwise the last result is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum  <= s;
            cout <= c[WIDTH];
         end
      end
   end

`ifdef SUMADOR_OVF_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (in_valid) begin
         ovf <= c[WIDTH] ^ c[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_sumador_completo.sv
// Scoreboard bench for sumador_completo at WIDTH 1, 8 and 16.
// Checks ovf as well when SUMADOR_OVF_EN is defined.
module tb_sumador_completo;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        v1 = 0, a1 = 0, b1 = 0, c1 = 0, s1, co1, ov1, o1;
   logic        v8 = 0, c8 = 0, co8, ov8, o8;
   logic [7:0]  a8 = 0, b8 = 0, s8;
   logic        v16 = 0, c16 = 0, co16, ov16, o16;
   logic [15:0] a16 = 0, b16 = 0, s16;

   exp_t q1[$], q8[$], q16[$];
   exp_t h1, h8, h16;

   int checks = 0;
   int errs   = 0;

   sumador_completo #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
      .sum(s1), .cout(co1),
`ifdef SUMADOR_OVF_EN
      .ovf(o1),
`endif
      .out_valid(ov1));

   sumador_completo #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
      .sum(s8), .cout(co8),
`ifdef SUMADOR_OVF_EN
      .ovf(o8),
`endif
      .out_valid(ov8));

   sumador_completo #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
      .sum(s16), .cout(co16),
`ifdef SUMADOR_OVF_EN
      .ovf(o16),
`endif
      .out_valid(ov16));

`ifndef SUMADOR_OVF_EN
   assign o1  = 1'b0;
   assign o8  = 1'b0;
   assign o16 = 1'b0;
`endif

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
      end
   endtask

   task automatic cmp(input string n, input logic [15:0] s, input logic c,
                      input logic o, input exp_t e);
      chk({n, ".sum"}, {16'b0, s}, {16'b0, e.s});
      chk({n, ".cout"}, {31'b0, c}, {31'b0, e.c});
`ifdef SUMADOR_OVF_EN
      chk({n, ".ovf"}, {31'b0, o}, {31'b0, e.o});
`else
      if (o !== 1'b0) chk({n, ".ovf"}, {31'b0, o}, 32'd0);
`endif
   endtask

   // Monitor: pops one expectation per out_valid, otherwise checks the hold.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            q1.delete(); q8.delete(); q16.delete();
            h1 = '0; h8 = '0; h16 = '0;
         end else begin
            if (ov1) begin
               if (q1.size() == 0) chk("w1.unexpected", 1, 0);
               else begin h1 = q1.pop_front(); cmp("w1", {15'b0, s1}, co1, o1, h1); end
            end else cmp("w1.hold", {15'b0, s1}, co1, o1, h1);
            if (ov8) begin
               if (q8.size() == 0) chk("w8.unexpected", 1, 0);
               else begin h8 = q8.pop_front(); cmp("w8", {8'b0, s8}, co8, o8, h8); end
            end else cmp("w8.hold", {8'b0, s8}, co8, o8, h8);
            if (ov16) begin
               if (q16.size() == 0) chk("w16.unexpected", 1, 0);
               else begin h16 = q16.pop_front(); cmp("w16", s16, co16, o16, h16); end
            end else cmp("w16.hold", s16, co16, o16, h16);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      v1 = 0; v8 = 0; v16 = 0;
   endtask

   task automatic go1(input logic [2:0] abc, input logic es, input logic ec, input logic eo);
      step();
      v1 = 1;
      {a1, b1, c1} = abc;
      q1.push_back('{s: {15'b0, es}, c: ec, o: eo});
   endtask

   task automatic go8(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] es, input logic ec, input logic eo);
      step();
      v8 = v; a8 = a; b8 = b; c8 = c;
      if (v) q8.push_back('{s: {8'b0, es}, c: ec, o: eo});
   endtask

   logic [2:0] t_s  = 3'b0;
   logic [7:0] tb_s = 8'b10010110;
   logic [7:0] tb_c = 8'b11101000;
   logic [7:0] tb_o = 8'b01000010;

   initial begin
      #2;
      chk("rst.w1.valid", {31'b0, ov1}, 0);
      chk("rst.w8.sum", {24'b0, s8}, 0);
      chk("rst.w16.cout", {31'b0, co16}, 0);
      chk("rst.w16.valid", {31'b0, ov16}, 0);
      @(posedge clk);
      #1 rst = 0;

      for (int i = 0; i < 8; i++) begin
         t_s = 3'(i);
         go1(t_s, tb_s[i], tb_c[i], tb_o[i]);
      end

      go8(1, 8'hFF, 8'h00, 1, 8'h00, 1, 0);
      go8(1, 8'hFF, 8'hFF, 1, 8'hFF, 1, 0);
      go8(1, 8'h7F, 8'h01, 0, 8'h80, 0, 1);
      go8(1, 8'h80, 8'h80, 0, 8'h00, 1, 1);
      go8(1, 8'h03, 8'h01, 0, 8'h04, 0, 0);
      go8(0, 8'h05, 8'h01, 0, 8'h00, 0, 0);
      go8(1, 8'h07, 8'h01, 0, 8'h08, 0, 0);
      step();
      step();

      // Async reset while a result is being presented.
      go8(1, 8'h12, 8'h34, 0, 8'h46, 0, 0);
      @(posedge clk);
      #1 v8 = 0;
      chk("mid.valid_before", {31'b0, ov8}, 1);
      #2 rst = 1;
      #1;
      chk("mid.valid", {31'b0, ov8}, 0);
      chk("mid.sum", {24'b0, s8}, 0);
      chk("mid.cout", {31'b0, co8}, 0);
      @(posedge clk);
      #1 rst = 0;
      go8(1, 8'h20, 8'h05, 1, 8'h26, 0, 0);
      step();
      step();

      for (int i = 0; i < 1000; i++) begin
         logic [15:0] ra, rb;
         logic        rc;
         logic [16:0] r;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         r  = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
         step();
         v16 = 1; a16 = ra; b16 = rb; c16 = rc;
         q16.push_back('{s: r[15:0], c: r[16],
                         o: (ra[15] == rb[15]) && (r[15] != ra[15])});
      end
      step();
      step();
      step();

      chk("drain.w1", q1.size(), 0);
      chk("drain.w8", q8.size(), 0);
      chk("drain.w16", q16.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
